csl_frame_decoder: RTL and testbench
====================================

Name: csl_frame_decoder

Overview:
- Upstream stage of the robot enable logic. Decodes a byte stream from the UART receiver into framed commands.
- Emits one-cycle `csl_valid` pulses for fault-location (CSL) frames and one-cycle `resolved` pulses for resolution frames. These feed the enabler's `csl_valid` and `resolved` inputs directly.
- Validates framing, checksum and inter-byte timing. Malformed frames are dropped and flagged.

Parameters:
- SOF, 8'hA5, start-of-frame byte
- TYPE_CSL, 8'h01, frame type carrying a CSL location payload
- TYPE_RES, 8'h02, frame type signalling fault resolved
- PAYLOAD_LEN, 2, payload bytes per frame (>=1)
- TIMEOUT_CYC, 50000, max clk cycles between consecutive bytes inside a frame (>=2)

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- rx_data  in  8  received byte
- rx_valid  in  1  one-cycle strobe; rx_data valid this cycle
- csl_valid  out  1  one-cycle pulse: good CSL frame decoded
- csl_data  out  8*PAYLOAD_LEN  payload of last good CSL frame; byte 0 in bits [7:0]
- resolved  out  1  one-cycle pulse: good RES frame decoded
- frame_err  out  1  one-cycle pulse: frame dropped
- busy  out  1  high while a frame is in progress (state != IDLE)

Behaviour:
- Reset: all outputs 0; csl_data = 0; FSM in IDLE; counters = 0.
- Frame format: SOF, TYPE, PAYLOAD_LEN payload bytes, CHK.
  - CHK = XOR of TYPE and all payload bytes.
  - Frame uses exactly one rx_valid strobe per byte.
- FSM states: IDLE, TYPE, PAYLOAD, CHECK.
  - IDLE: rx_valid with rx_data == SOF -> TYPE. Any other byte is ignored silently (no error).
  - TYPE: store byte, seed running XOR with it, idx = 0 -> PAYLOAD. Unknown type values are still accepted here; they are rejected at CHECK.
  - PAYLOAD: store byte at shadow[idx], XOR into running checksum, idx++. When idx reaches PAYLOAD_LEN-1 on an accepted byte -> CHECK.
  - CHECK: on byte, -> IDLE and resolve the frame as follows.
    - Byte equals running XOR and type == TYPE_CSL: csl_data <= shadow and csl_valid = 1, both taking effect in the same cycle.
    - Byte equals running XOR and type == TYPE_RES: resolved = 1; csl_data unchanged.
    - Otherwise (bad checksum or unknown type): frame_err = 1.
- Latency: each pulse is registered and asserted on the clk edge that follows the cycle in which the CHK byte is sampled. That is 1 cycle after the CHK strobe. Each pulse is exactly 1 cycle wide.
- At most one of csl_valid, resolved and frame_err is high in any cycle.
- SOF values inside TYPE, PAYLOAD or CHECK are treated as data. There is no resynchronisation mid-frame.
- Timeout:
  - Gap counter clears on every rx_valid and when the FSM is in IDLE; it increments every cycle the FSM is not IDLE and no byte arrives.
  - When it reaches TIMEOUT_CYC: frame_err pulse, FSM -> IDLE, partial payload discarded, csl_data unchanged.
  - If rx_valid arrives on the same cycle the counter would hit TIMEOUT_CYC, the byte wins and the counter clears.
  - The counter is clog2(TIMEOUT_CYC+1) bits wide and never wraps.
- Back-to-back frames: an SOF arriving the cycle after CHK is accepted normally. No idle gap is required.
- A failed frame does not alter csl_data. Shadow payload is copied only on a good CSL frame.
- Asserting reset_n low mid-frame aborts immediately: no pulse, no frame_err, csl_data cleared to 0.
- busy = (state != IDLE), driven combinationally from the state register.

Decomposition:
- Shared package csl_pkg holds:
  - SOF, TYPE_CSL and TYPE_RES constants
  - the state enum {IDLE, TYPE, PAYLOAD, CHECK}
  - the frame-field widths, so the enabler, the UART TX echo and the testbench agree on encoding
- One natural sub-module: csl_byte_timeout (gap counter with clear/enable inputs and an expire output), reusable by the TX path.
- FSM and payload shadow stay in this module.

Test Plan:
- Good CSL frame: A5 01 3C 07 CHK=3A -> csl_valid one cycle, 1 cycle after CHK strobe; csl_data=16'h073C; resolved and frame_err stay 0.
- Good RES frame after a CSL frame: A5 02 00 00 CHK=02 -> resolved one cycle; csl_data still 16'h073C; csl_valid stays 0.
- Bad checksum: A5 01 11 22 CHK=00 -> frame_err one cycle; csl_valid 0; csl_data unchanged. Unknown type A5 05 00 00 CHK=05 -> frame_err.
- Timeout (TIMEOUT_CYC=10 in bench): A5 01 then 10 idle cycles -> frame_err pulse, busy falls. A byte arriving exactly on cycle 10 -> no error, frame continues.
- Noise and embedded SOF: 00 FF A5 01 A5 A5 CHK=01 -> leading bytes ignored; payload 16'hA5A5 accepted; csl_valid asserts.
- Reset mid-frame: A5 01 3C, drop reset_n for 2 cycles, then a full good frame -> no pulse from the aborted frame; csl_data=0 after reset; second frame decodes correctly.

Source files
------------

// File: rtl/csl_pkg.sv
// Shared encoding for the CSL command link: framing bytes, field widths and decoder states.
// Imported by the decoder, the enabler and the UART TX echo so all agree on the wire format.
package csl_pkg;

    localparam int BYTE_W = 8;

    typedef logic [BYTE_W-1:0] byte_t;

    localparam byte_t SOF      = 8'hA5;
    localparam byte_t TYPE_CSL = 8'h01;
    localparam byte_t TYPE_RES = 8'h02;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        TYPE    = 2'd1,
        PAYLOAD = 2'd2,
        CHECK   = 2'd3
    } state_t;

endpackage

// File: rtl/csl_frame_decoder_if.sv
// Byte-stream input and decoded-command outputs of the CSL frame decoder.
// The master side feeds bytes and observes the pulses; the slave side is the decoder.
interface csl_frame_decoder_if #(
    parameter int PAYLOAD_LEN = 2
);
    import csl_pkg::*;

    byte_t                          rx_data;
    logic                           rx_valid;
    logic                           csl_valid;
    logic [BYTE_W*PAYLOAD_LEN-1:0]  csl_data;
    logic                           resolved;
    logic                           frame_err;
    logic                           busy;

    modport master (
        output rx_data,
        output rx_valid,
        input  csl_valid,
        input  csl_data,
        input  resolved,
        input  frame_err,
        input  busy
    );

    modport slave (
        input  rx_data,
        input  rx_valid,
        output csl_valid,
        output csl_data,
        output resolved,
        output frame_err,
        output busy
    );

endinterface

// File: rtl/csl_byte_timeout.sv
// Inter-byte gap counter: counts enabled cycles since the last clear and flags expiry
// on the cycle that would reach TIMEOUT_CYC. A clear on that same cycle suppresses expiry.
module csl_byte_timeout #(
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    logic [CNT_W-1:0] cnt_q;

    assign expire = enable && !clear && (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

    // Saturates at TIMEOUT_CYC so the count never wraps back into a valid window.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
        end else if (enable && (cnt_q != CNT_W'(TIMEOUT_CYC))) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/csl_frame_decoder.sv
// Decodes SOF/TYPE/PAYLOAD/CHK frames from the UART byte stream into csl_valid/resolved
// pulses, dropping malformed or stalled frames with a frame_err pulse.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | hunting for SOF; other bytes ignored silently
// TYPE    | next byte is the frame type; seeds the running checksum
// PAYLOAD | collecting payload bytes into the shadow buffer
// CHECK   | next byte is CHK; resolves the frame and returns to IDLE
module csl_frame_decoder
    import csl_pkg::*;
#(
    parameter int PAYLOAD_LEN = 2,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic                clk,
    input  logic                reset_n,
    csl_frame_decoder_if.slave  bus
);

    localparam int PL_W  = BYTE_W * PAYLOAD_LEN;
    localparam int IDX_W = (PAYLOAD_LEN > 1) ? $clog2(PAYLOAD_LEN) : 1;

    state_t             state, state_nxt;
    byte_t              type_q, type_nxt;
    byte_t              xor_q, xor_nxt;
    logic [IDX_W-1:0]   idx_q, idx_nxt;
    logic [PL_W-1:0]    shadow_q, shadow_nxt;
    logic [PL_W-1:0]    csl_data_q, csl_data_nxt;
    logic               csl_valid_q, csl_valid_nxt;
    logic               resolved_q, resolved_nxt;
    logic               frame_err_q, frame_err_nxt;
    logic               expire;
    logic               in_frame;

    assign in_frame = (state != IDLE);

    csl_byte_timeout #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_byte_timeout (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (bus.rx_valid || !in_frame),
        .enable  (in_frame),
        .expire  (expire)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            type_q      <= '0;
            xor_q       <= '0;
            idx_q       <= '0;
            shadow_q    <= '0;
            csl_data_q  <= '0;
            csl_valid_q <= 1'b0;
            resolved_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state       <= state_nxt;
            type_q      <= type_nxt;
            xor_q       <= xor_nxt;
            idx_q       <= idx_nxt;
            shadow_q    <= shadow_nxt;
            csl_data_q  <= csl_data_nxt;
            csl_valid_q <= csl_valid_nxt;
            resolved_q  <= resolved_nxt;
            frame_err_q <= frame_err_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        type_nxt      = type_q;
        xor_nxt       = xor_q;
        idx_nxt       = idx_q;
        shadow_nxt    = shadow_q;
        csl_data_nxt  = csl_data_q;
        csl_valid_nxt = 1'b0;
        resolved_nxt  = 1'b0;
        frame_err_nxt = 1'b0;

        if (expire) begin
            state_nxt     = IDLE;
            frame_err_nxt = 1'b1;
        end else if (bus.rx_valid) begin
            case (state)
                IDLE: begin
                    if (bus.rx_data == SOF) begin
                        state_nxt = TYPE;
                    end
                end
                TYPE: begin
                    // Unknown types are carried through and rejected at CHECK.
                    type_nxt  = bus.rx_data;
                    xor_nxt   = bus.rx_data;
                    idx_nxt   = '0;
                    state_nxt = PAYLOAD;
                end
                PAYLOAD: begin
                    shadow_nxt[idx_q*BYTE_W +: BYTE_W] = bus.rx_data;
                    xor_nxt = xor_q ^ bus.rx_data;
                    if (idx_q == IDX_W'(PAYLOAD_LEN - 1)) begin
                        state_nxt = CHECK;
                    end else begin
                        idx_nxt = idx_q + IDX_W'(1);
                    end
                end
                CHECK: begin
                    state_nxt = IDLE;
                    if ((bus.rx_data == xor_q) && (type_q == TYPE_CSL)) begin
                        csl_data_nxt  = shadow_q;
                        csl_valid_nxt = 1'b1;
                    end else if ((bus.rx_data == xor_q) && (type_q == TYPE_RES)) begin
                        resolved_nxt  = 1'b1;
                    end else begin
                        frame_err_nxt = 1'b1;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    assign bus.csl_valid = csl_valid_q;
    assign bus.csl_data  = csl_data_q;
    assign bus.resolved  = resolved_q;
    assign bus.frame_err = frame_err_q;
    assign bus.busy      = in_frame;

endmodule

// File: tb/tb_csl_frame_decoder.sv
// Directed plus randomized frames for csl_frame_decoder, checked against a frame-level
// reference model (checksum/type rules) and a pulse-counting monitor.
module tb_csl_frame_decoder;
    import csl_pkg::*;

    localparam int PL  = 2;
    localparam int TMO = 10;

    logic clk;
    logic reset_n;

    csl_frame_decoder_if #(.PAYLOAD_LEN(PL)) bus ();

    csl_frame_decoder #(
        .PAYLOAD_LEN (PL),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int exp_csl = 0, exp_res = 0, exp_err = 0;
    int mon_csl = 0, mon_res = 0, mon_err = 0;
    logic [PL*8-1:0] model_data = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Pulse monitor: counts every high cycle and requires the three pulses to be exclusive.
    always @(negedge clk) begin
        mon_csl += int'(bus.csl_valid);
        mon_res += int'(bus.resolved);
        mon_err += int'(bus.frame_err);
        if (bus.csl_valid || bus.resolved || bus.frame_err)
            check("pulse_onehot", 32'($countones({bus.csl_valid, bus.resolved, bus.frame_err})), 32'd1);
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input byte_t b);
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
    endtask

    function automatic int pick_gap(input int gmax);
        if (gmax == 0) return 0;
        if ($urandom_range(0, 7) == 0) return TMO - 1;
        return int'($urandom_range(0, gmax));
    endfunction

    // Outcome {csl, res, err} from the frame rules: CHK must equal XOR of TYPE and payload.
    function automatic logic [2:0] ref_outcome(input byte_t t, input logic [PL*8-1:0] p, input byte_t c);
        byte_t x = t;
        for (int i = 0; i < PL; i++) x ^= p[i*8 +: 8];
        if (c != x) return 3'b001;
        if (t == TYPE_CSL) return 3'b100;
        if (t == TYPE_RES) return 3'b010;
        return 3'b001;
    endfunction

    function automatic byte_t good_chk(input byte_t t, input logic [PL*8-1:0] p);
        byte_t x = t;
        for (int i = 0; i < PL; i++) x ^= p[i*8 +: 8];
        return x;
    endfunction

    task automatic check_idle_outputs(input string tag);
        check({tag, "_pulses"}, 32'({bus.csl_valid, bus.resolved, bus.frame_err}), 32'd0);
        check({tag, "_data"}, 32'(bus.csl_data), 32'(model_data));
    endtask

    task automatic run_frame(input string tag, input byte_t t, input logic [PL*8-1:0] p,
                             input byte_t c, input int gmax);
        logic [2:0] eo;
        eo = ref_outcome(t, p, c);
        send_byte(SOF);
        idle(pick_gap(gmax));
        send_byte(t);
        for (int i = 0; i < PL; i++) begin
            idle(pick_gap(gmax));
            send_byte(p[i*8 +: 8]);
        end
        idle(pick_gap(gmax));
        send_byte(c);
        if (eo[2]) model_data = p;
        exp_csl += int'(eo[2]);
        exp_res += int'(eo[1]);
        exp_err += int'(eo[0]);
        check({tag, "_pulses"}, 32'({bus.csl_valid, bus.resolved, bus.frame_err}), 32'(eo));
        check({tag, "_data"}, 32'(bus.csl_data), 32'(model_data));
        check({tag, "_busy"}, 32'(bus.busy), 32'd0);
    endtask

    logic [7:0]      t, c;
    logic [PL*8-1:0] p;
    int              kind, k;

    initial begin
        reset_n      = 1'b0;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        idle(3);
        check("reset_pulses", 32'({bus.csl_valid, bus.resolved, bus.frame_err}), 32'd0);
        check("reset_data", 32'(bus.csl_data), 32'd0);
        check("reset_busy", 32'(bus.busy), 32'd0);
        reset_n = 1'b1;
        idle(2);

        run_frame("good_csl", 8'h01, 16'h073C, 8'h3A, 0);
        check("good_csl_value", 32'(bus.csl_data), 32'h073C);
        idle(1);
        check_idle_outputs("good_csl_after");
        run_frame("good_res", 8'h02, 16'h0000, 8'h02, 0);
        idle(1);
        run_frame("bad_chk", 8'h01, 16'h2211, 8'h00, 0);
        idle(1);
        run_frame("unknown_type", 8'h05, 16'h0000, 8'h05, 0);
        check("unknown_keeps_data", 32'(bus.csl_data), 32'h073C);
        idle(2);

        // Stall after TYPE: the tenth idle cycle expires the frame.
        send_byte(SOF);
        send_byte(8'h01);
        idle(TMO - 1);
        check("tmo_pre_err", 32'(bus.frame_err), 32'd0);
        check("tmo_pre_busy", 32'(bus.busy), 32'd1);
        idle(1);
        exp_err++;
        check("tmo_err", 32'(bus.frame_err), 32'd1);
        check("tmo_busy", 32'(bus.busy), 32'd0);
        check("tmo_data", 32'(bus.csl_data), 32'(model_data));
        idle(1);
        check_idle_outputs("tmo_after");

        // A byte on the would-be expiry cycle wins and the frame completes.
        send_byte(SOF);
        send_byte(8'h01);
        idle(TMO - 1);
        send_byte(8'h34);
        check("edge_no_err", 32'(bus.frame_err), 32'd0);
        check("edge_busy", 32'(bus.busy), 32'd1);
        idle(TMO - 1);
        send_byte(8'h12);
        idle(TMO - 1);
        send_byte(8'h01 ^ 8'h34 ^ 8'h12);
        model_data = 16'h1234;
        exp_csl++;
        check("edge_csl", 32'({bus.csl_valid, bus.resolved, bus.frame_err}), 32'b100);
        check("edge_data", 32'(bus.csl_data), 32'h1234);
        idle(1);

        send_byte(8'h00);
        send_byte(8'hFF);
        check("noise_busy", 32'(bus.busy), 32'd0);
        run_frame("embedded_sof", 8'h01, 16'hA5A5, 8'h01, 0);
        // Back-to-back: SOF the cycle right after CHK.
        run_frame("b2b_res", 8'h02, 16'h5A01, 8'h02 ^ 8'h5A ^ 8'h01, 0);
        run_frame("b2b_csl", 8'h01, 16'hBEEF, 8'h01 ^ 8'hBE ^ 8'hEF, 0);
        idle(1);

        send_byte(SOF);
        send_byte(8'h01);
        send_byte(8'h3C);
        reset_n = 1'b0;
        idle(2);
        model_data = '0;
        check_idle_outputs("midrst");
        check("midrst_busy", 32'(bus.busy), 32'd0);
        reset_n = 1'b1;
        idle(1);
        run_frame("post_rst", 8'h01, 16'h073C, 8'h3A, 0);
        idle(1);

        for (int n = 0; n < 40; n++) begin
            k = int'($urandom_range(0, 2));
            for (int j = 0; j < k; j++) begin
                t = 8'($urandom);
                if (t == SOF) t = 8'h00;
                send_byte(t);
            end
            for (int i = 0; i < PL; i++)
                p[i*8 +: 8] = ($urandom_range(0, 3) == 0) ? SOF : 8'($urandom);
            kind = int'($urandom_range(0, 4));
            case (kind)
                0: run_frame("rnd_csl", TYPE_CSL, p, good_chk(TYPE_CSL, p), 2);
                1: run_frame("rnd_res", TYPE_RES, p, good_chk(TYPE_RES, p), 2);
                2: begin
                    t = 8'($urandom);
                    run_frame("rnd_badchk", t, p, good_chk(t, p) ^ 8'($urandom_range(1, 255)), 2);
                end
                3: begin
                    t = 8'($urandom_range(3, 255));
                    run_frame("rnd_unknown", t, p, good_chk(t, p), 2);
                end
                default: begin
                    k = int'($urandom_range(0, PL + 1));
                    send_byte(SOF);
                    for (int j = 0; j < k; j++) send_byte((j == 0) ? TYPE_CSL : p[(j-1)*8 +: 8]);
                    idle(TMO);
                    exp_err++;
                    check("rnd_tmo_err", 32'(bus.frame_err), 32'd1);
                    check("rnd_tmo_busy", 32'(bus.busy), 32'd0);
                    check("rnd_tmo_data", 32'(bus.csl_data), 32'(model_data));
                end
            endcase
            if ($urandom_range(0, 1) == 1) idle(int'($urandom_range(1, 3)));
        end
        idle(3);

        check("count_csl", 32'(mon_csl), 32'(exp_csl));
        check("count_res", 32'(mon_res), 32'(exp_res));
        check("count_err", 32'(mon_err), 32'(exp_err));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
